// File: rtl/l1_dcache_pkg.sv
// Shared types for the L1 data cache: controller states and line geometry.
package l1_dcache_pkg;

  localparam int S_OFFSET   = 5;
  localparam int LINE_W     = 256;
  localparam int LINE_BYTES = LINE_W / 8;

  typedef enum logic [1:0] {
    CHECK,
    WRITEBACK,
    FILL
  } dcache_state_t;

endpackage

// File: rtl/l1_dcache_cache_array.sv
// Storage array with a combinational read port and a byte-masked synchronous write port.
// The data array uses one mask bit per byte; the tag array is written whole with an all-ones mask.
module cache_array #(
  parameter int WIDTH = 256,
  parameter int IDX_W = 3,
  parameter int MASK_W = (WIDTH + 7) / 8
) (
  input  logic              clk,
  input  logic              i_load,
  input  logic [IDX_W-1:0]  i_index,
  input  logic [MASK_W-1:0] i_mask,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata
);

  localparam int DEPTH = 1 << IDX_W;

  logic [WIDTH-1:0] r_mem [DEPTH];

  assign o_rdata = r_mem[i_index];

  // Update only the bytes selected by the mask; the contents are never reset.
  always_ff @(posedge clk) begin
    if (i_load) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (i_mask[b / 8]) begin
          r_mem[i_index][b] <= i_wdata[b];
        end
      end
    end
  end

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// Hits answer in the request cycle. A miss writes back a dirty victim, fills the line, then answers.
module l1_dcache
  import l1_dcache_pkg::*;
#(
  parameter int S_INDEX = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [31:0]         mem_address,
  input  logic [31:0]         mem_wdata,
  input  logic [3:0]          mem_byte_enable,
  output logic                mem_resp,
  output logic [31:0]         mem_rdata,
  output logic                pmem_read,
  output logic                pmem_write,
  output logic [31:0]         pmem_address,
  output logic [LINE_W-1:0]   pmem_wdata,
  input  logic [LINE_W-1:0]   pmem_rdata,
  input  logic                pmem_resp
);

  localparam int TAG_W   = 27 - S_INDEX;
  localparam int SETS    = 1 << S_INDEX;
  localparam int TMASK_W = (TAG_W + 7) / 8;

  dcache_state_t r_state, w_nextState;

  logic [SETS-1:0]       r_valid, r_dirty;
  logic [TAG_W-1:0]      r_missTag;
  logic [S_INDEX-1:0]    r_missIndex;

  logic [TAG_W-1:0]      w_reqTag, w_storedTag;
  logic [S_INDEX-1:0]    w_reqIndex, w_arrIndex;
  logic [2:0]            w_reqWord;
  logic [LINE_W-1:0]     w_storedLine, w_dataWdata;
  logic [LINE_BYTES-1:0] w_dataMask;
  logic                  w_request, w_hit, w_hitResp, w_hitWrite, w_fillDone, w_dataLoad;
  logic [1:0]            w_unusedAddrBits;

  assign w_reqTag         = mem_address[31 -: TAG_W];
  assign w_reqIndex       = mem_address[S_OFFSET +: S_INDEX];
  assign w_reqWord        = mem_address[4:2];
  assign w_unusedAddrBits = mem_address[1:0];

  assign w_request  = mem_read | mem_write;
  assign w_arrIndex = (r_state == CHECK) ? w_reqIndex : r_missIndex;
  assign w_hit      = r_valid[w_reqIndex] && (w_storedTag == w_reqTag);
  assign w_hitResp  = (r_state == CHECK) && w_request && w_hit;
  assign w_hitWrite = w_hitResp && mem_write;
  assign w_fillDone = (r_state == FILL) && pmem_resp;

  cache_array #(.WIDTH(LINE_W), .IDX_W(S_INDEX)) u_dataArray (
    .clk     (clk),
    .i_load  (w_dataLoad),
    .i_index (w_arrIndex),
    .i_mask  (w_dataMask),
    .i_wdata (w_dataWdata),
    .o_rdata (w_storedLine)
  );

  cache_array #(.WIDTH(TAG_W), .IDX_W(S_INDEX)) u_tagArray (
    .clk     (clk),
    .i_load  (w_fillDone),
    .i_index (w_arrIndex),
    .i_mask  ({TMASK_W{1'b1}}),
    .i_wdata (r_missTag),
    .o_rdata (w_storedTag)
  );

  // Choose the data-array write: a whole-line fill, or a store merged into one word of the line.
  always_comb begin
    w_dataLoad  = 1'b0;
    w_dataMask  = '0;
    w_dataWdata = {8{mem_wdata}};
    if (w_fillDone) begin
      w_dataLoad  = 1'b1;
      w_dataMask  = '1;
      w_dataWdata = pmem_rdata;
    end else if (w_hitWrite) begin
      w_dataLoad  = 1'b1;
      w_dataMask  = 32'(mem_byte_enable) << {w_reqWord, 2'b00};
    end
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= CHECK;
    else      r_state <= w_nextState;
  end

  // Miss sequencing: dirty victims are written back before the fill.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      CHECK: begin
        if (w_request && !w_hit) begin
          w_nextState = (r_valid[w_reqIndex] && r_dirty[w_reqIndex]) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: if (pmem_resp) w_nextState = FILL;
      FILL:      if (pmem_resp) w_nextState = CHECK;
      default:   w_nextState = CHECK;
    endcase
  end

  // Drive the CPU and memory ports; pmem fields come from registered miss info so they stay stable.
  always_comb begin
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (r_state)
      CHECK: begin
        mem_resp = w_hitResp;
        if (w_hitResp) mem_rdata = w_storedLine[{w_reqWord, 5'b00000} +: 32];
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {w_storedTag, r_missIndex, 5'b00000};
        pmem_wdata   = w_storedLine;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {r_missTag, r_missIndex, 5'b00000};
      end
      default: ;
    endcase
  end

  // Latch the missing line's tag and index so the miss completes even if the request drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_missTag   <= '0;
      r_missIndex <= '0;
    end else if ((r_state == CHECK) && w_request && !w_hit) begin
      r_missTag   <= w_reqTag;
      r_missIndex <= w_reqIndex;
    end
  end

  // Line status: a fill makes the line valid and clean, a store hit marks it dirty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (w_fillDone) begin
      r_valid[r_missIndex] <= 1'b1;
      r_dirty[r_missIndex] <= 1'b0;
    end else if (w_hitWrite) begin
      r_dirty[w_reqIndex] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l1_dcache.sv
// Directed self-checking bench for l1_dcache with a behavioural line memory on the pmem port.
module tb_l1_dcache;

   logic         clk;
   logic         rst;
   logic         mem_read, mem_write;
   logic [31:0]  mem_address, mem_wdata;
   logic [3:0]   mem_byte_enable;
   logic         mem_resp;
   logic [31:0]  mem_rdata;
   logic         pmem_read, pmem_write;
   logic [31:0]  pmem_address;
   logic [255:0] pmem_wdata, pmem_rdata;
   logic         pmem_resp;

   int checkCount = 0;
   int passCount  = 0;

   // Backing store, one 256-bit line per entry, indexed by address[12:5]
   logic [255:0] memLines [256];

   // Results of the most recent transaction
   logic         txnResp, txnOverlap, txnUnstable;
   logic [31:0]  txnRdata, txnWbAddr, txnFillAddr;
   logic [255:0] txnWbData, expLine;
   int           txnLatency, txnLastPmemResp, txnWbCount, txnFillCount;

   l1_dcache #(.S_INDEX(3)) dut (
      .clk             (clk),
      .rst             (rst),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_byte_enable (mem_byte_enable),
      .mem_resp        (mem_resp),
      .mem_rdata       (mem_rdata),
      .pmem_read       (pmem_read),
      .pmem_write      (pmem_write),
      .pmem_address    (pmem_address),
      .pmem_wdata      (pmem_wdata),
      .pmem_rdata      (pmem_rdata),
      .pmem_resp       (pmem_resp)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count one comparison and report it if the observed value differs from the expected one
   task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
      checkCount++;
      if (observed !== expected)
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      else
         passCount++;
   endtask

   // Hold one CPU request (starting at a falling edge) until mem_resp or the cycle budget runs out,
   // acting as the memory: each pmem request is answered on its 'delay'-th cycle
   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] mbe, input int delay);
      int cyc, cnt;
      logic active;
      logic [31:0] firstAddr;
      txnResp = 0; txnOverlap = 0; txnUnstable = 0; txnRdata = '0;
      txnWbAddr = '0; txnFillAddr = '0; txnWbData = '0;
      txnLatency = -1; txnLastPmemResp = -1; txnWbCount = 0; txnFillCount = 0;
      mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wdata; mem_byte_enable = mbe;
      cyc = 0; cnt = 0; active = 0; firstAddr = '0;
      while (!txnResp && cyc < 200) begin
         #1;
         if (pmem_read && pmem_write) txnOverlap = 1;
         if (pmem_read || pmem_write) begin
            if (!active) begin
               active = 1; firstAddr = pmem_address; cnt = 0;
            end else if (pmem_address !== firstAddr) begin
               txnUnstable = 1;
            end
            cnt++;
            if (cnt == delay) begin
               active = 0;
               pmem_resp = 1;
               txnLastPmemResp = cyc;
               if (pmem_write) begin
                  txnWbCount++; txnWbAddr = pmem_address; txnWbData = pmem_wdata;
                  memLines[pmem_address[12:5]] = pmem_wdata;
               end else begin
                  txnFillCount++; txnFillAddr = pmem_address;
                  pmem_rdata = memLines[pmem_address[12:5]];
               end
            end
         end
         if (mem_resp) begin
            txnResp = 1; txnRdata = mem_rdata; txnLatency = cyc;
         end
         @(negedge clk);
         pmem_resp = 0;
         cyc++;
      end
      mem_read = 0; mem_write = 0;
   endtask

   initial begin
      // Memory image: word n of line L is 0x2000_0000 + L*256 + n, except line 0x40 uses 0x1000_0000 + n
      for (int i = 0; i < 256; i++)
         for (int n = 0; n < 8; n++)
            memLines[i][32*n +: 32] = 32'h2000_0000 + 32'(i * 256) + 32'(n);
      for (int n = 0; n < 8; n++) memLines[2][32*n +: 32] = 32'h1000_0000 + 32'(n);

      rst = 0; mem_read = 0; mem_write = 0; mem_address = '0; mem_wdata = '0;
      mem_byte_enable = '0; pmem_rdata = '0; pmem_resp = 0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("resetMemResp", mem_resp, 0);
      checkOutput("resetPmemRead", pmem_read, 0);
      checkOutput("resetPmemWrite", pmem_write, 0);
      checkOutput("resetPmemAddr", pmem_address, 0);
      checkOutput("resetPmemWdata", pmem_wdata, 0);
      checkOutput("resetRdata", mem_rdata, 0);
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      #1;
      checkOutput("idleMemResp", mem_resp, 0);
      checkOutput("idlePmemRead", pmem_read, 0);
      @(negedge clk);

      // Cold read: fill of 0x40 answered on its third cycle, mem_resp one cycle later
      applyStimulus(1, 0, 32'h40, 0, 0, 3);
      checkOutput("coldResp", txnResp, 1);
      checkOutput("coldFillCount", txnFillCount, 1);
      checkOutput("coldFillAddr", txnFillAddr, 32'h40);
      checkOutput("coldWbCount", txnWbCount, 0);
      checkOutput("coldLatency", txnLatency, 4);
      checkOutput("coldRdata", txnRdata, 32'h1000_0000);

      // Read hit on the neighbouring word
      applyStimulus(1, 0, 32'h44, 0, 0, 1);
      checkOutput("hitResp", txnResp, 1);
      checkOutput("hitLatency", txnLatency, 0);
      checkOutput("hitPmem", txnFillCount + txnWbCount, 0);
      checkOutput("hitRdata", txnRdata, 32'h1000_0001);

      // Byte store to lane 1, then read the word back in the very next cycle
      applyStimulus(0, 1, 32'h45, 32'h0000_AB00, 4'b0010, 1);
      checkOutput("storeLatency", txnLatency, 0);
      applyStimulus(1, 0, 32'h44, 0, 0, 1);
      checkOutput("storeReadLatency", txnLatency, 0);
      checkOutput("storeReadRdata", txnRdata, 32'h1000_AB01);

      // Dirty conflict: writeback of the merged 0x40 line, then fill of 0x140
      expLine = memLines[2];
      expLine[63:32] = 32'h1000_AB01;
      applyStimulus(1, 0, 32'h140, 0, 0, 3);
      checkOutput("dirtyResp", txnResp, 1);
      checkOutput("dirtyWbCount", txnWbCount, 1);
      checkOutput("dirtyWbAddr", txnWbAddr, 32'h40);
      checkOutput("dirtyWbData", txnWbData, expLine);
      checkOutput("dirtyFillAddr", txnFillAddr, 32'h140);
      checkOutput("dirtyLatency", txnLatency, 7);
      checkOutput("dirtyRespAfterFill", txnLatency, txnLastPmemResp + 1);
      checkOutput("dirtyRdata", txnRdata, 32'h2000_0A00);
      checkOutput("dirtyOverlap", txnOverlap, 0);
      checkOutput("dirtyAddrStable", txnUnstable, 0);

      // Slow memory: fill of 0x240 answered on its tenth cycle, one single mem_resp at the end
      applyStimulus(1, 0, 32'h248, 0, 0, 10);
      checkOutput("slowWbCount", txnWbCount, 0);
      checkOutput("slowLatency", txnLatency, 11);
      checkOutput("slowRdata", txnRdata, 32'h2000_1202);
      checkOutput("slowAddrStable", txnUnstable, 0);
      #1;
      checkOutput("slowSinglePulse", mem_resp, 0);
      @(negedge clk);

      // Write miss allocates the line, then the stored word hits
      applyStimulus(0, 1, 32'h84, 32'hDEAD_BEEF, 4'b1111, 2);
      checkOutput("wmissFillAddr", txnFillAddr, 32'h80);
      checkOutput("wmissLatency", txnLatency, 3);
      applyStimulus(1, 0, 32'h84, 0, 0, 1);
      checkOutput("wmissReadLatency", txnLatency, 0);
      checkOutput("wmissReadRdata", txnRdata, 32'hDEAD_BEEF);

      // Reset in the middle of a fill of 0x40
      mem_read = 1; mem_address = 32'h40;
      repeat (2) @(negedge clk);
      #1;
      checkOutput("midFillPmemRead", pmem_read, 1);
      rst = 0;
      #1;
      checkOutput("rstDropPmemRead", pmem_read, 0);
      checkOutput("rstDropPmemAddr", pmem_address, 0);
      checkOutput("rstDropMemResp", mem_resp, 0);
      @(negedge clk);
      rst = 1; mem_read = 0;
      @(negedge clk);

      // After reset the index-4 line is gone too: reading 0x84 must refill without a writeback
      applyStimulus(1, 0, 32'h40, 0, 0, 2);
      checkOutput("postRstFillCount", txnFillCount, 1);
      checkOutput("postRstLatency", txnLatency, 3);
      checkOutput("postRstRdata", txnRdata, 32'h1000_0000);
      applyStimulus(1, 0, 32'h84, 0, 0, 2);
      checkOutput("postRstDirtyGone", txnWbCount, 0);
      checkOutput("postRstRefill", txnFillCount, 1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
